// File: rtl/data_mem_arbiter.sv
// MEM-stage data memory arbiter: the CPU pipeline has priority, and a secondary loader/debug master
// (B) is served through a one-entry holding register with a bounded wait.
module data_mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        A_MemRead,
  input  logic        A_MemWrite,
  input  logic [1:0]  A_ByteSel,
  input  logic [31:0] A_Address,
  input  logic [31:0] A_WriteData,
  output logic [31:0] A_ReadData,
  output logic        Stall,
  input  logic        B_Req,
  input  logic        B_Write,
  input  logic [1:0]  B_ByteSel,
  input  logic [31:0] B_Address,
  input  logic [31:0] B_WriteData,
  output logic        B_Ready,
  output logic        B_Ack,
  output logic [31:0] B_ReadData,
  output logic [31:0] M_Address,
  output logic [31:0] M_WriteData,
  output logic [1:0]  M_ByteSel,
  output logic        M_MemRead,
  output logic        M_MemWrite,
  input  logic [31:0] M_ReadData,
  output logic        DbgState
);

  localparam int CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} stateType;

  stateType        state, nextState;
  logic [CntW-1:0] waitCnt;
  logic            heldWrite;
  logic [1:0]      heldByteSel;
  logic [31:0]     heldAddress;
  logic [31:0]     heldWriteData;
  logic            cpuAct, pending, grantA, grantB, capture;

  // B handshake: a request transfers on a rising edge where B_Req=1 and B_Ready=1.
  // When B_Ready=0, a request is dropped and is not queued. B_Ack pulses for one
  // cycle after the access is performed.
  assign cpuAct  = A_MemRead | A_MemWrite;
  assign pending = (state == HELD);
  assign capture = (state == IDLE) & B_Req;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (B_Req)  nextState = HELD;
      HELD:    if (grantB) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    grantB     = pending & (~cpuAct | (waitCnt == MaxCnt));
    grantA     = cpuAct & ~grantB;
    Stall      = cpuAct & grantB;
    B_Ready    = ~pending;
    DbgState   = state;
    A_ReadData = M_ReadData;
    if (grantB) begin
      M_Address   = heldAddress;
      M_WriteData = heldWriteData;
      M_ByteSel   = heldByteSel;
      M_MemRead   = ~heldWrite;
      M_MemWrite  = heldWrite;
    end else begin
      // The address, data and ByteSel lines follow A even when nothing is granted.
      M_Address   = A_Address;
      M_WriteData = A_WriteData;
      M_ByteSel   = A_ByteSel;
      M_MemRead   = grantA & A_MemRead;
      M_MemWrite  = grantA & A_MemWrite;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      heldWrite     <= 1'b0;
      heldByteSel   <= 2'b00;
      heldAddress   <= 32'h0;
      heldWriteData <= 32'h0;
    end else if (capture) begin
      heldWrite     <= B_Write;
      heldByteSel   <= B_ByteSel;
      heldAddress   <= B_Address;
      heldWriteData <= B_WriteData;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      waitCnt    <= '0;
      B_Ack      <= 1'b0;
      B_ReadData <= 32'h0;
    end else begin
      B_Ack <= grantB;
      if (grantB) waitCnt <= '0;
      else if (pending && grantA && waitCnt != MaxCnt) waitCnt <= waitCnt + CntW'(1);
      if (grantB && !heldWrite) B_ReadData <= M_ReadData;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: it instantiates one arbiter with MAX_WAIT=4 and one with
// MAX_WAIT=0 on shared inputs, and gives each its own word-addressed memory.
module tb_data_mem_arbiter;

  logic        clk, rstN;
  logic        aMemRead, aMemWrite, bReq, bWrite;
  logic [1:0]  aByteSel, bByteSel;
  logic [31:0] aAddress, aWriteData, bAddress, bWriteData;

  logic [31:0] aReadData4, bReadData4, mAddress4, mWriteData4, mReadData4;
  logic [1:0]  mByteSel4;
  logic        stall4, bReady4, bAck4, mMemRead4, mMemWrite4, dbg4;
  logic [31:0] aReadData0, bReadData0, mAddress0, mWriteData0, mReadData0;
  logic [1:0]  mByteSel0;
  logic        stall0, bReady0, bAck0, mMemRead0, mMemWrite0, dbg0;

  logic [31:0] mem4 [0:63];
  logic [31:0] mem0 [0:63];

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(.MAX_WAIT(4)) dut4 (
    .Clock(clk), .Reset_n(rstN),
    .A_MemRead(aMemRead), .A_MemWrite(aMemWrite), .A_ByteSel(aByteSel),
    .A_Address(aAddress), .A_WriteData(aWriteData), .A_ReadData(aReadData4),
    .Stall(stall4),
    .B_Req(bReq), .B_Write(bWrite), .B_ByteSel(bByteSel), .B_Address(bAddress),
    .B_WriteData(bWriteData), .B_Ready(bReady4), .B_Ack(bAck4), .B_ReadData(bReadData4),
    .M_Address(mAddress4), .M_WriteData(mWriteData4), .M_ByteSel(mByteSel4),
    .M_MemRead(mMemRead4), .M_MemWrite(mMemWrite4), .M_ReadData(mReadData4),
    .DbgState(dbg4)
  );

  data_mem_arbiter #(.MAX_WAIT(0)) dut0 (
    .Clock(clk), .Reset_n(rstN),
    .A_MemRead(aMemRead), .A_MemWrite(aMemWrite), .A_ByteSel(aByteSel),
    .A_Address(aAddress), .A_WriteData(aWriteData), .A_ReadData(aReadData0),
    .Stall(stall0),
    .B_Req(bReq), .B_Write(bWrite), .B_ByteSel(bByteSel), .B_Address(bAddress),
    .B_WriteData(bWriteData), .B_Ready(bReady0), .B_Ack(bAck0), .B_ReadData(bReadData0),
    .M_Address(mAddress0), .M_WriteData(mWriteData0), .M_ByteSel(mByteSel0),
    .M_MemRead(mMemRead0), .M_MemWrite(mMemWrite0), .M_ReadData(mReadData0),
    .DbgState(dbg0)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models: combinational read, write on the edge, preload on reset.
  assign mReadData4 = mem4[mAddress4[7:2]];
  assign mReadData0 = mem0[mAddress0[7:2]];

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 64; i++) begin
        mem4[i] <= 32'(i);
        mem0[i] <= 32'(i);
      end
      mem4[4]  <= 32'hA5A5_A5A5;  mem0[4]  <= 32'hA5A5_A5A5;
      mem4[16] <= 32'hDEAD_BEEF;  mem0[16] <= 32'hDEAD_BEEF;
      mem4[17] <= 32'h4444_4444;  mem0[17] <= 32'h4444_4444;
      mem4[18] <= 32'h4848_4848;  mem0[18] <= 32'h4848_4848;
    end else begin
      if (mMemWrite4) mem4[mAddress4[7:2]] <= mWriteData4;
      if (mMemWrite0) mem0[mAddress0[7:2]] <= mWriteData0;
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rstN = 1'b0;
    aMemRead = 1'b0; aMemWrite = 1'b0; aByteSel = 2'b00; aAddress = 32'h0; aWriteData = 32'h0;
    bReq = 1'b0; bWrite = 1'b0; bByteSel = 2'b00; bAddress = 32'h0; bWriteData = 32'h0;

    // Values while reset is held
    #2;
    chk("rst_ready", bReady4, 1);
    chk("rst_ack", bAck4, 0);
    chk("rst_rdata", bReadData4, 32'h0);
    chk("rst_stall", stall4, 0);
    chk("rst_mrd", mMemRead4, 0);
    chk("rst_mwr", mMemWrite4, 0);
    #8 rstN = 1'b1;
    tick;

    // B read with the CPU idle
    bReq = 1'b1; bWrite = 1'b0; bAddress = 32'h40; bByteSel = 2'b11;
    #1 chk("t1_ready_n", bReady4, 1);
    tick;
    bReq = 1'b0;
    #1;
    chk("t1_mrd", mMemRead4, 1);
    chk("t1_addr", mAddress4, 32'h40);
    chk("t1_stall", stall4, 0);
    chk("t1_ack_early", bAck4, 0);
    chk("t1_state", dbg4, 1);
    tick;
    chk("t1_ack", bAck4, 1);
    chk("t1_rdata", bReadData4, 32'hDEAD_BEEF);
    chk("t1_ready", bReady4, 1);
    chk("t1_stall2", stall4, 0);
    tick;
    chk("t1_ack_pulse", bAck4, 0);

    // MAX_WAIT=4: CPU loads every cycle while a B write waits
    aMemRead = 1'b1; aAddress = 32'h10; aByteSel = 2'b11;
    bReq = 1'b1; bWrite = 1'b1; bAddress = 32'h80; bWriteData = 32'h1234_5678; bByteSel = 2'b01;
    #1 chk("t2_c0_stall", stall4, 0);
    tick;
    bReq = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_cpu_stall", stall4, 0);
      chk("t2_cpu_mrd", mMemRead4, 1);
      chk("t2_cpu_bytesel", mByteSel4, 2'b11);
      chk("t2_cpu_rdata", aReadData4, 32'hA5A5_A5A5);
      tick;
    end
    #1;
    chk("t2_b_stall", stall4, 1);
    chk("t2_b_mwr", mMemWrite4, 1);
    chk("t2_b_mrd", mMemRead4, 0);
    chk("t2_b_addr", mAddress4, 32'h80);
    chk("t2_b_bytesel", mByteSel4, 2'b01);
    chk("t2_b_wdata", mWriteData4, 32'h1234_5678);
    tick;
    aAddress = 32'h80;
    #1;
    chk("t2_after_stall", stall4, 0);
    chk("t2_after_ack", bAck4, 1);
    chk("t2_rdata_hold", bReadData4, 32'hDEAD_BEEF);
    chk("t2_load_back", aReadData4, 32'h1234_5678);
    tick;
    aMemRead = 1'b0;

    // MAX_WAIT=0: B wins over a CPU store
    rstN = 1'b0;
    tick;
    rstN = 1'b1;
    bReq = 1'b1; bWrite = 1'b0; bAddress = 32'h40;
    #1 chk("t3_ready", bReady0, 1);
    tick;
    bReq = 1'b0;
    aMemWrite = 1'b1; aAddress = 32'h20; aWriteData = 32'hCAFE_F00D; aByteSel = 2'b11;
    #1;
    chk("t3_stall", stall0, 1);
    chk("t3_mrd", mMemRead0, 1);
    chk("t3_mwr", mMemWrite0, 0);
    chk("t3_addr", mAddress0, 32'h40);
    chk("t3_w4_nostall", stall4, 0);
    tick;
    chk("t3_stall_off", stall0, 0);
    chk("t3_store", mMemWrite0, 1);
    chk("t3_store_addr", mAddress0, 32'h20);
    chk("t3_ack", bAck0, 1);
    chk("t3_rdata", bReadData0, 32'hDEAD_BEEF);
    tick;
    aMemWrite = 1'b0; aMemRead = 1'b1;
    #1 chk("t3_load_back", aReadData0, 32'hCAFE_F00D);
    tick;
    aMemRead = 1'b0;

    // B_Req held for three cycles
    rstN = 1'b0;
    tick;
    rstN = 1'b1;
    bReq = 1'b1; bWrite = 1'b0; bAddress = 32'h40;
    #1 chk("t4_ready0", bReady4, 1);
    tick;
    bAddress = 32'h44;
    #1;
    chk("t4_busy", bReady4, 0);
    chk("t4_addr1", mAddress4, 32'h40);
    tick;
    bAddress = 32'h48;
    #1;
    chk("t4_ack1", bAck4, 1);
    chk("t4_ready1", bReady4, 1);
    chk("t4_rdata1", bReadData4, 32'hDEAD_BEEF);
    tick;
    bReq = 1'b0;
    #1;
    chk("t4_addr3", mAddress4, 32'h48);
    chk("t4_mrd3", mMemRead4, 1);
    chk("t4_noack", bAck4, 0);
    tick;
    chk("t4_ack3", bAck4, 1);
    chk("t4_rdata3", bReadData4, 32'h4848_4848);
    tick;
    chk("t4_no_extra_ack", bAck4, 0);
    chk("t4_idle_ready", bReady4, 1);

    // Reset while HELD with WaitCnt=2
    aMemRead = 1'b1; aAddress = 32'h10;
    bReq = 1'b1; bWrite = 1'b1; bAddress = 32'h84; bWriteData = 32'h55;
    tick;
    bReq = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t5_wait_stall", stall4, 0);
      tick;
    end
    #1 rstN = 1'b0;
    #1;
    chk("t5_rst_ready", bReady4, 1);
    chk("t5_rst_stall", stall4, 0);
    chk("t5_rst_ack", bAck4, 0);
    tick;
    rstN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t5_never_ack", bAck4, 0);
      chk("t5_no_stall", stall4, 0);
      tick;
    end
    aMemRead = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Arbitrates the single-ported data memory in the MEM stage between the CPU pipeline (requester A) and a secondary loader/debug master (requester B). CPU accesses have priority. A bounded-wait counter guarantees B is served, and the CPU is stalled for exactly the cycle B is granted. The block sits between the MEM-stage control signals and the data memory's Address/WriteData/ByteSel/MemRead/MemWrite/ReadData pins. Stall feeds the hazard unit.

## Interface
- MAX_WAIT, 4, max consecutive cycles a pending B request can lose to the CPU before B is forced (0 = B always wins)
- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- A_MemRead  in  1  CPU load this cycle
- A_MemWrite  in  1  CPU store this cycle
- A_ByteSel  in  2  CPU byte select
- A_Address  in  32  CPU address
- A_WriteData  in  32  CPU store data
- A_ReadData  out  32  CPU load data, combinational from M_ReadData
- Stall  out  1  CPU access not serviced this cycle; hold MEM stage
- B_Req  in  1  B request, sampled when B_Ready=1
- B_Write  in  1  1=write, 0=read (with B_Req)
- B_ByteSel  in  2  B byte select
- B_Address  in  32  B address
- B_WriteData  in  32  B write data
- B_Ready  out  1  holding register empty
- B_Ack  out  1  one-cycle completion pulse
- B_ReadData  out  32  registered B read data
- M_Address, M_WriteData  out  32  to data memory
- M_ByteSel  out  2  to data memory
- M_MemRead, M_MemWrite  out  1  to data memory
- M_ReadData  in  32  from data memory (combinational read)

## Operation
- CpuAct = A_MemRead | A_MemWrite.
- B holding register:
  - On a clock edge with B_Req=1 and B_Ready=1, capture B_Write, B_ByteSel, B_Address and B_WriteData, and set Pending=1.
  - B_Ready = !Pending.
  - B_Req while B_Ready=0 is ignored. It is not queued.
- GrantB = Pending & (!CpuAct | WaitCnt == MAX_WAIT). GrantA = CpuAct & !GrantB. Both are combinational.
- Stall = CpuAct & GrantB.
- Memory mux:
  - GrantB: M_* driven from the holding register. M_MemWrite = held Write, M_MemRead = !held Write.
  - GrantA: M_* driven from the A_* inputs.
  - Neither: M_MemRead = M_MemWrite = 0, and address/data/ByteSel follow the A_* inputs.
- A_ReadData = M_ReadData at all times. It is valid only when GrantA=1.
- WaitCnt, width clog2(MAX_WAIT+1):
  - Increments on an edge where Pending & GrantA.
  - Clears on an edge where GrantB.
  - Holds otherwise.
  - Saturates at MAX_WAIT.
- On an edge with GrantB:
  - Pending clears.
  - B_Ack is set for the next cycle only.
  - If the access was a read, B_ReadData loads M_ReadData. B_ReadData holds until the next B read completes.
- States:
  - IDLE (Pending=0) goes to HELD on accepted B_Req.
  - HELD (Pending=1, GrantB=0) stays HELD and WaitCnt counts.
  - HELD with GrantB=1 goes to IDLE, and B_Ack fires next cycle.

## Timing
- Reset values while Reset_n=0:
  - Pending=0, WaitCnt=0.
  - B_Ready=1, B_Ack=0, B_ReadData=0.
  - Stall=0, M_MemRead=M_MemWrite=0.
- Reset asserted mid-transaction discards the held B request with no B_Ack. Any CPU access that cycle is passed through unstalled.
- B latency with CPU idle:
  - Request edge N.
  - Memory access during cycle N+1.
  - B_Ack and B_ReadData valid in cycle N+2, with B_Ready=1 in the same cycle.
- Maximum B throughput is one transaction per 2 cycles.
- Under continuous CPU traffic, B is granted no later than MAX_WAIT+1 cycles after capture.
- Stall is high only in B-granted cycles, so there is never more than one consecutive stall cycle per B transaction.
- A CPU access in a non-stalled cycle completes that cycle: the store commits on the edge, and the load data is valid combinationally.

## Test plan
- Reset, then B read of 0x0000_0040 (memory holds 0xDEADBEEF) with CPU idle:
  - M_MemRead=1 with M_Address=0x40 in cycle N+1.
  - B_Ack=1 and B_ReadData=0xDEADBEEF in cycle N+2 only.
  - Stall stays 0 throughout.
- MAX_WAIT=4, CPU issues loads every cycle, B write 0x12345678 to 0x80 is captured:
  - The CPU is served for 4 cycles.
  - In the 5th cycle Stall=1, M_MemWrite=1 and M_Address=0x80.
  - The next cycle has Stall=0 and B_Ack=1.
  - A subsequent CPU load of 0x80 returns 0x12345678.
- MAX_WAIT=0, CPU store active when B is pending:
  - B is granted the first pending cycle with Stall=1.
  - The CPU store commits the following cycle.
- B_Req held high for 3 cycles with different addresses:
  - Only the first (B_Ready=1) is captured.
  - The second is ignored.
  - The third is captured after B_Ack.
- B_ByteSel=2'b01 write vs A_ByteSel=2'b11: M_ByteSel follows the granted requester each cycle.
- Reset_n pulsed low during a HELD state with WaitCnt=2:
  - Pending=0, B_Ready=1 and Stall=0 immediately.
  - No B_Ack is ever generated for the discarded request.
